// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants and types.
//   - State/word widths, round constants (RCON) and the forward S-box table.
//   - FSM state type for the AddRoundKey / key-schedule block.
// Byte order follows the datapath convention: vectors are [0:N-1], byte 0 = bits [0:7].
package aes_pkg;

  localparam int unsigned StateW = 128;
  localparam int unsigned WordW  = 32;

  typedef enum logic [1:0] {
    StIdle,    // no key loaded
    StReady,   // round key for the current round is valid
    StExpand   // deriving the next round key
  } ark_state_e;

  // Forward S-box, entry n at bits [8*n +: 8] (entry 0 leftmost).
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constant for rounds 0..9; any other index yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    case (round)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/add_round_key_ksched_if.sv
// add_round_key_ksched_if: key load, input-state and output-result handshakes.
//   slave  : the AddRoundKey block (takes key/state, drives result)
//   master : the upstream/downstream side driving key/state and consuming results
interface add_round_key_ksched_if;

  logic         key_load;
  logic [0:127] key_in;
  logic         state_valid;
  logic         state_ready;
  logic [0:127] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] state_out;
  logic [3:0]   out_round;
  logic         out_last;

  modport slave (
    input  key_load, key_in, state_valid, state_in, out_ready,
    output state_ready, out_valid, state_out, out_round, out_last
  );

  modport master (
    output key_load, key_in, state_valid, state_in, out_ready,
    input  state_ready, out_valid, state_out, out_round, out_last
  );

endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: 8-bit combinational AES forward S-box lookup.
//   i_byte : input byte
//   o_byte : SubBytes(i_byte)
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  logic [10:0] w_base;

  assign w_base = {i_byte, 3'b000};
  assign o_byte = SBOX[w_base +: 8];

endmodule

// File: rtl/add_round_key_ksched.sv
// add_round_key_ksched: AddRoundKey with on-the-fly AES-128 key expansion.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of add_round_key_ksched_if
//          key_load/key_in            - load cipher key (pulse)
//          state_valid/ready/state_in - input state handshake
//          out_valid/ready/state_out/out_round/out_last - registered result
// Each accepted state is XORed with the current round key. The following round
// key is derived in a dedicated EXPAND cycle, so only the cipher key (for block
// restart) and the current round key are stored. Only NR = 10 is supported.
module add_round_key_ksched
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  add_round_key_ksched_if.slave bus
);

  localparam logic [3:0] LastRound = 4'(NR);

  ark_state_e   r_state;
  ark_state_e   w_state_nxt;
  logic [3:0]   r_round;
  logic [0:127] r_rk;
  logic [0:127] r_key0;
  logic [0:127] r_state_out;
  logic [3:0]   r_out_round;
  logic         r_out_last;
  logic         r_out_valid;

  logic         w_state_ready;
  logic         w_accept;
  logic         w_last_round;

  // ---------------------------------------------------------------------------
  // Next round key
  // ---------------------------------------------------------------------------
  logic [0:31]  w_w0, w_w1, w_w2, w_w3;
  logic [0:31]  w_rot, w_sub, w_t;
  logic [0:31]  w_n0, w_n1, w_n2, w_n3;
  logic [0:127] w_next_key;

  assign w_w0  = r_rk[0:31];
  assign w_w1  = r_rk[32:63];
  assign w_w2  = r_rk[64:95];
  assign w_w3  = r_rk[96:127];
  assign w_rot = {w_w3[8:31], w_w3[0:7]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (w_rot[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  assign w_t        = w_sub ^ {rcon(r_round), 24'h000000};
  assign w_n0       = w_w0 ^ w_t;
  assign w_n1       = w_w1 ^ w_n0;
  assign w_n2       = w_w2 ^ w_n1;
  assign w_n3       = w_w3 ^ w_n2;
  assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.key_load) begin
      // Loading a key overrides everything, including an in-flight expansion.
      w_state_nxt = StReady;
    end else begin
      case (r_state)
        StIdle:   w_state_nxt = StIdle;
        StReady:  if (w_accept && !w_last_round) w_state_nxt = StExpand;
        StExpand: w_state_nxt = StReady;
        default:  w_state_nxt = StIdle;
      endcase
    end
  end

  always_comb begin
    w_last_round  = (r_round == LastRound);
    // Can take a state only when the output slot is free or draining now.
    w_state_ready = (r_state == StReady) && !bus.key_load &&
                    (!r_out_valid || bus.out_ready);
    w_accept      = bus.state_valid && w_state_ready;
  end

  // ---------------------------------------------------------------------------
  // Key schedule registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key0  <= '0;
      r_rk    <= '0;
      r_round <= '0;
    end else if (bus.key_load) begin
      r_key0  <= bus.key_in;
      r_rk    <= bus.key_in;
      r_round <= '0;
    end else if (w_accept && w_last_round) begin
      // Final round done: rewind to the cipher key for the next block.
      r_rk    <= r_key0;
      r_round <= '0;
    end else if (r_state == StExpand) begin
      r_rk    <= w_next_key;
      r_round <= r_round + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_out <= '0;
      r_out_round <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_state_out <= bus.state_in ^ r_rk;
      r_out_round <= r_round;
      r_out_last  <= w_last_round;
      r_out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.state_ready = w_state_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.state_out   = r_state_out;
  assign bus.out_round   = r_out_round;
  assign bus.out_last    = r_out_last;

endmodule

// File: tb/tb_add_round_key_ksched.sv
// tb_add_round_key_ksched: directed bench for add_round_key_ksched using the
// FIPS-197 AES-128 example key schedule.
module tb_add_round_key_ksched;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  add_round_key_ksched_if bus ();

  add_round_key_ksched #(
    .NR (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [127:0] Key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Key2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] Pt   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] R0   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

  logic [127:0] rk_exp [1:10];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one state, wait (bounded) for ready, then check the registered result.
  task automatic send(input logic [127:0] st, input logic [127:0] exp, input int rnd,
                      input bit last, input string tag);
    int n;
    n = 0;
    bus.state_valid = 1'b1;
    bus.state_in    = st;
    #1;
    while (bus.state_ready !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk({tag, " ready"}, 128'(bus.state_ready), 128'd1);
    step();
    bus.state_valid = 1'b0;
    bus.state_in    = '0;
    chk({tag, " out_valid"}, 128'(bus.out_valid), 128'd1);
    chk({tag, " state_out"}, bus.state_out, exp);
    chk({tag, " out_round"}, 128'(bus.out_round), 128'(rnd));
    chk({tag, " out_last"}, 128'(bus.out_last), 128'(last));
  endtask

  initial begin
    rk_exp[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_exp[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_exp[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_exp[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_exp[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_exp[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_exp[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_exp[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk_exp[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk_exp[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst             = 1'b1;
    bus.key_load    = 1'b0;
    bus.key_in      = '0;
    bus.state_valid = 1'b0;
    bus.state_in    = '0;
    bus.out_ready   = 1'b1;

    // Reset values
    #2;
    chk("rst out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst state_ready", 128'(bus.state_ready), 128'd0);
    chk("rst state_out", bus.state_out, 128'd0);
    chk("rst out_round", 128'(bus.out_round), 128'd0);
    chk("rst out_last", 128'(bus.out_last), 128'd0);
    #10;
    rst = 1'b0;
    step();

    // IDLE never accepts
    bus.state_valid = 1'b1;
    #1;
    chk("idle ready", 128'(bus.state_ready), 128'd0);
    bus.state_valid = 1'b0;

    // Key load and round 0 with FIPS-197 plaintext
    bus.key_load = 1'b1;
    bus.key_in   = Key;
    step();
    bus.key_load = 1'b0;
    send(Pt, R0, 0, 1'b0, "r0");
    chk("expand ready", 128'(bus.state_ready), 128'd0);

    // Rounds 1..10 with zero states expose the round keys
    for (int r = 1; r <= 10; r++) begin
      send(128'd0, rk_exp[r], r, (r == 10), $sformatf("r%0d", r));
    end

    // Back-to-back restart without reload
    chk("b2b ready", 128'(bus.state_ready), 128'd1);
    send(128'd0, Key, 0, 1'b0, "restart");

    // Backpressure: hold out_ready low for 5 cycles
    bus.out_ready   = 1'b0;
    bus.state_valid = 1'b1;
    bus.state_in    = 128'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp%0d ready", i), 128'(bus.state_ready), 128'd0);
      chk($sformatf("bp%0d state_out", i), bus.state_out, Key);
      chk($sformatf("bp%0d valid", i), 128'(bus.out_valid), 128'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp release ready", 128'(bus.state_ready), 128'd1);
    step();
    bus.state_valid = 1'b0;
    chk("bp r1 valid", 128'(bus.out_valid), 128'd1);
    chk("bp r1 state_out", bus.state_out, rk_exp[1]);
    chk("bp r1 round", 128'(bus.out_round), 128'd1);

    // key_load during EXPAND aborts and restarts at round 0 with the new key
    bus.key_load = 1'b1;
    bus.key_in   = Key2;
    #1;
    chk("abort ready", 128'(bus.state_ready), 128'd0);
    step();
    bus.key_load = 1'b0;
    chk("abort drained", 128'(bus.out_valid), 128'd0);
    send(128'd0, Key2, 0, 1'b0, "abort");

    // Simultaneous key_load and state_valid: key loads, state not taken
    step();
    bus.key_load    = 1'b1;
    bus.key_in      = Key2;
    bus.state_valid = 1'b1;
    bus.state_in    = Pt;
    #1;
    chk("kl+sv ready", 128'(bus.state_ready), 128'd0);
    step();
    bus.key_load    = 1'b0;
    bus.state_valid = 1'b0;
    chk("kl+sv no accept", 128'(bus.out_valid), 128'd0);
    send(128'd0, Key2, 0, 1'b0, "reload");

    // Async reset between clock edges
    bus.out_ready   = 1'b0;
    bus.state_valid = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk("arst out_valid", 128'(bus.out_valid), 128'd0);
    chk("arst state_ready", 128'(bus.state_ready), 128'd0);
    chk("arst state_out", bus.state_out, 128'd0);
    #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("arst idle%0d ready", i), 128'(bus.state_ready), 128'd0);
      chk($sformatf("arst idle%0d valid", i), 128'(bus.out_valid), 128'd0);
    end
    bus.state_valid = 1'b0;
    bus.key_load    = 1'b1;
    bus.key_in      = Key;
    step();
    bus.key_load = 1'b0;
    send(Pt, R0, 0, 1'b0, "post rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
